// File: rtl/regfile_banked.sv
// Dual-banked register file with same-cycle write forwarding, interrupt bank swap
// and a handshaked sequencer that streams the active bank out for debug/context save.
module regfile_banked #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned ADDR_W   = 3,
  parameter bit          ZERO_REG = 1'b0
) (
  input  logic              Clock,
  input  logic              nReset,
  input  logic              We,
  input  logic [ADDR_W-1:0] Rw,
  input  logic [WIDTH-1:0]  WData,
  input  logic [ADDR_W-1:0] Rs1,
  input  logic [ADDR_W-1:0] Rs2,
  output logic [WIDTH-1:0]  Rd1,
  output logic [WIDTH-1:0]  Rd2,
  input  logic              IntEnter,
  input  logic              IntReturn,
  output logic              Bank,
  input  logic              DumpReq,
  input  logic              DumpReady,
  output logic              DumpValid,
  output logic [WIDTH-1:0]  DumpData,
  output logic [ADDR_W-1:0] DumpAddr,
  output logic              DumpBusy,
  output logic              DumpDone
);

  localparam int unsigned NREG = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DUMP = 2'd1,
    S_DONE = 2'd2
  } dump_state_e;

  logic [WIDTH-1:0]  regs_q [2][NREG];
  logic              bank_q, bank_d;
  logic              wr_en_c;
  dump_state_e       state_q;
  logic              dbank_q;
  logic [ADDR_W-1:0] daddr_q;
  logic              dvalid_q;
  logic              dbusy_q;
  logic              ddone_q;

  // A write to r0 is dropped when r0 is hard-wired to zero.
  assign wr_en_c = We && !(ZERO_REG && (Rw == '0));

  // IntEnter has priority; entering while already in bank 1 is a no-op.
  always_comb begin
    bank_d = bank_q;
    if (IntEnter) begin
      bank_d = 1'b1;
    end else if (IntReturn) begin
      bank_d = 1'b0;
    end
  end

  // Storage and bank select; writes in a switching cycle land in the old bank.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      regs_q <= '{default: '0};
      bank_q <= 1'b0;
    end else begin
      if (wr_en_c) begin
        regs_q[bank_q][Rw] <= WData;
      end
      bank_q <= bank_d;
    end
  end

  // Read ports with write forwarding.
  always_comb begin
    Rd1 = regs_q[bank_q][Rs1];
    Rd2 = regs_q[bank_q][Rs2];
    if (ZERO_REG && (Rs1 == '0)) begin
      Rd1 = '0;
    end else if (wr_en_c && (Rw == Rs1)) begin
      Rd1 = WData;
    end
    if (ZERO_REG && (Rs2 == '0)) begin
      Rd2 = '0;
    end else if (wr_en_c && (Rw == Rs2)) begin
      Rd2 = WData;
    end
  end

  // Dump sequencer: one register per accepted beat, then a single DONE cycle.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q  <= S_IDLE;
      dbank_q  <= 1'b0;
      daddr_q  <= '0;
      dvalid_q <= 1'b0;
      dbusy_q  <= 1'b0;
      ddone_q  <= 1'b0;
    end else begin
      ddone_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (DumpReq) begin
            state_q  <= S_DUMP;
            dbank_q  <= bank_q;
            daddr_q  <= '0;
            dvalid_q <= 1'b1;
            dbusy_q  <= 1'b1;
          end
        end
        S_DUMP: begin
          if (DumpReady) begin
            daddr_q <= daddr_q + ADDR_W'(1);
            if (daddr_q == ADDR_W'(NREG - 1)) begin
              state_q  <= S_DONE;
              dvalid_q <= 1'b0;
              ddone_q  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          dbusy_q <= 1'b0;
        end
        default: begin
          state_q  <= S_IDLE;
          dvalid_q <= 1'b0;
          dbusy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Live read of the dumped bank, gated to zero outside a beat.
  always_comb begin
    DumpData = '0;
    if (dvalid_q && !(ZERO_REG && (daddr_q == '0))) begin
      DumpData = regs_q[dbank_q][daddr_q];
    end
  end

  assign Bank      = bank_q;
  assign DumpValid = dvalid_q;
  assign DumpAddr  = daddr_q;
  assign DumpBusy  = dbusy_q;
  assign DumpDone  = ddone_q;

endmodule

// File: tb/tb_regfile_banked.sv
// Scoreboard bench for regfile_banked: one instance with ZERO_REG=0 and one with
// ZERO_REG=1 share all inputs; expectations are queued as stimulus is driven.
module tb_regfile_banked;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned NREG   = 8;

  logic              Clock = 1'b0;
  logic              nReset, We, IntEnter, IntReturn, DumpReq, DumpReady;
  logic [ADDR_W-1:0] Rw, Rs1, Rs2;
  logic [WIDTH-1:0]  WData;

  logic [WIDTH-1:0]  Rd1, Rd2, DumpData;
  logic              Bank, DumpValid, DumpBusy, DumpDone;
  logic [ADDR_W-1:0] DumpAddr;

  logic [WIDTH-1:0]  Rd1_z, Rd2_z, DumpData_z;
  logic              Bank_z, DumpValid_z, DumpBusy_z, DumpDone_z;
  logic [ADDR_W-1:0] DumpAddr_z;

  regfile_banked #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .ZERO_REG(1'b0)) dut (
    .Clock(Clock), .nReset(nReset), .We(We), .Rw(Rw), .WData(WData),
    .Rs1(Rs1), .Rs2(Rs2), .Rd1(Rd1), .Rd2(Rd2),
    .IntEnter(IntEnter), .IntReturn(IntReturn), .Bank(Bank),
    .DumpReq(DumpReq), .DumpReady(DumpReady), .DumpValid(DumpValid),
    .DumpData(DumpData), .DumpAddr(DumpAddr), .DumpBusy(DumpBusy), .DumpDone(DumpDone)
  );

  regfile_banked #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .ZERO_REG(1'b1)) dut_z (
    .Clock(Clock), .nReset(nReset), .We(We), .Rw(Rw), .WData(WData),
    .Rs1(Rs1), .Rs2(Rs2), .Rd1(Rd1_z), .Rd2(Rd2_z),
    .IntEnter(IntEnter), .IntReturn(IntReturn), .Bank(Bank_z),
    .DumpReq(DumpReq), .DumpReady(DumpReady), .DumpValid(DumpValid_z),
    .DumpData(DumpData_z), .DumpAddr(DumpAddr_z), .DumpBusy(DumpBusy_z), .DumpDone(DumpDone_z)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cyc, beats, last_beat_cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] got);
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_empty_on_pop", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, got, e.val);
    end
  endtask

  task automatic step();
    @(negedge Clock);
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < int'(NREG); a++) begin
      Rs1 = ADDR_W'(a);
      Rs2 = ADDR_W'(int'(NREG) - 1 - a);
      #1;
      sb_push({tag, "_rd1"}, 32'd0);
      sb_push({tag, "_rd2"}, 32'd0);
      sb_pop(32'(Rd1));
      sb_pop(32'(Rd2));
      step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nReset = 1'b0; We = 1'b0; Rw = '0; WData = '0; Rs1 = '0; Rs2 = '0;
    IntEnter = 1'b0; IntReturn = 1'b0; DumpReq = 1'b0; DumpReady = 1'b0;
    step();
    step();
    #1;
    check("rst_bank", 32'(Bank), 32'd0);
    check("rst_dvalid", 32'(DumpValid), 32'd0);
    check("rst_ddata", 32'(DumpData), 32'd0);
    check("rst_daddr", 32'(DumpAddr), 32'd0);
    check("rst_dbusy", 32'(DumpBusy), 32'd0);
    check("rst_ddone", 32'(DumpDone), 32'd0);
    check("rst_rd1", 32'(Rd1), 32'd0);
    nReset = 1'b1;
    step();

    read_all("b0");
    IntEnter = 1'b1;
    step();
    IntEnter = 1'b0;
    #1 check("enter_bank", 32'(Bank), 32'd1);
    read_all("b1");
    IntReturn = 1'b1;
    step();
    IntReturn = 1'b0;
    #1 check("return_bank", 32'(Bank), 32'd0);

    // Forwarding on r3
    We = 1'b1; Rw = 3'd3; WData = 16'hBEEF; Rs1 = 3'd3;
    #1;
    sb_push("fwd_rd1", 32'h0000_BEEF);
    sb_pop(32'(Rd1));
    step();
    We = 1'b0;
    #1;
    sb_push("stored_rd1", 32'h0000_BEEF);
    sb_pop(32'(Rd1));

    // r0 behaviour with and without the zero register
    We = 1'b1; Rw = 3'd0; WData = 16'h1234; Rs1 = 3'd0; Rs2 = 3'd0;
    #1;
    sb_push("z_r0_nofwd", 32'd0);
    sb_pop(32'(Rd1_z));
    sb_push("r0_fwd", 32'h0000_1234);
    sb_pop(32'(Rd1));
    step();
    We = 1'b0;
    #1;
    sb_push("z_r0_stored", 32'd0);
    sb_pop(32'(Rd2_z));
    sb_push("r0_stored", 32'h0000_1234);
    sb_pop(32'(Rd2));

    // Bank isolation and switch timing
    We = 1'b1; Rw = 3'd5; WData = 16'h00AA;
    step();
    We = 1'b0; IntEnter = 1'b1; Rs1 = 3'd5;
    #1;
    sb_push("pulse_old_bank", 32'h0000_00AA);
    sb_pop(32'(Rd1));
    step();
    IntEnter = 1'b0;
    #1 check("b1_bank", 32'(Bank), 32'd1);
    We = 1'b1; Rw = 3'd5; WData = 16'h0055;
    step();
    We = 1'b0;
    #1;
    sb_push("b1_r5", 32'h0000_0055);
    sb_pop(32'(Rd1));
    IntReturn = 1'b1;
    #1;
    sb_push("ret_pulse_old", 32'h0000_0055);
    sb_pop(32'(Rd1));
    step();
    IntReturn = 1'b0;
    #1;
    sb_push("b0_r5", 32'h0000_00AA);
    sb_pop(32'(Rd1));
    check("ret_bank", 32'(Bank), 32'd0);

    // Write in the switching cycle lands in the old bank
    IntEnter = 1'b1; We = 1'b1; Rw = 3'd6; WData = 16'h0066; Rs1 = 3'd6;
    step();
    IntEnter = 1'b0; We = 1'b0;
    #1;
    sb_push("b1_r6_untouched", 32'd0);
    sb_pop(32'(Rd1));
    IntReturn = 1'b1;
    step();
    IntReturn = 1'b0;
    #1;
    sb_push("b0_r6_switch_write", 32'h0000_0066);
    sb_pop(32'(Rd1));

    IntEnter = 1'b1; IntReturn = 1'b1;
    step();
    IntEnter = 1'b0; IntReturn = 1'b0;
    #1 check("enter_wins", 32'(Bank), 32'd1);
    IntReturn = 1'b1;
    step();
    IntReturn = 1'b0;
    #1 check("back_to_b0", 32'(Bank), 32'd0);

    // Load rN = N + 0x100 and dump with DumpReady held high
    for (int n = 0; n < int'(NREG); n++) begin
      We = 1'b1; Rw = ADDR_W'(n); WData = WIDTH'(16'h0100 + n);
      step();
    end
    We = 1'b0;
    for (int i = 0; i < int'(NREG); i++) begin
      sb_push("dump_data", 32'h0100 + 32'(i));
      sb_push("dump_addr", 32'(i));
    end
    DumpReq = 1'b1; DumpReady = 1'b1;
    step();
    DumpReq = 1'b0;
    done_cyc = -1; beats = 0; last_beat_cyc = -1;
    for (int c = 1; c <= 20 && done_cyc < 0; c++) begin
      #1;
      if (DumpValid) begin
        sb_pop(32'(DumpData));
        sb_pop(32'(DumpAddr));
        if (DumpAddr == '0) check("z_dump_r0", 32'(DumpData_z), 32'd0);
        beats++;
        last_beat_cyc = c;
      end
      if (DumpDone) begin
        done_cyc = c;
        DumpReq  = 1'b1;
      end
      step();
      DumpReq = 1'b0;
    end
    check("dump_beats", 32'(beats), 32'd8);
    check("dump_last_beat_cyc", 32'(last_beat_cyc), 32'd8);
    check("dump_done_cyc", 32'(done_cyc), 32'd9);
    #1;
    check("req_in_done_ignored_valid", 32'(DumpValid), 32'd0);
    check("idle_busy", 32'(DumpBusy), 32'd0);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    // Stalled beat, live write, then reset mid-dump
    DumpReq = 1'b1; DumpReady = 1'b1;
    step();
    DumpReq = 1'b0;
    #1;
    sb_push("st_beat0", 32'h0000_0100);
    sb_pop(32'(DumpData));
    step();
    #1;
    sb_push("st_beat1", 32'h0000_0101);
    sb_pop(32'(DumpData));
    step();
    DumpReady = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1;
      sb_push("stall_data", 32'h0000_0102);
      sb_push("stall_addr", 32'd2);
      sb_pop(32'(DumpData));
      sb_pop(32'(DumpAddr));
      if (s == 2) begin
        We = 1'b1; Rw = 3'd2; WData = 16'h0222;
      end
      step();
    end
    We = 1'b0;
    #1;
    sb_push("stall_live_write", 32'h0000_0222);
    sb_pop(32'(DumpData));
    check("stall_busy", 32'(DumpBusy), 32'd1);
    nReset = 1'b0;
    #1;
    check("mid_rst_valid", 32'(DumpValid), 32'd0);
    check("mid_rst_busy", 32'(DumpBusy), 32'd0);
    check("mid_rst_data", 32'(DumpData), 32'd0);
    step();
    nReset = 1'b1; DumpReady = 1'b1; DumpReq = 1'b1;
    step();
    DumpReq = 1'b0;
    #1;
    check("restart_valid", 32'(DumpValid), 32'd1);
    check("restart_addr", 32'(DumpAddr), 32'd0);
    check("restart_data_cleared", 32'(DumpData), 32'd0);
    step();
    #1 check("restart_addr1", 32'(DumpAddr), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
